// File: rtl/pwm_audio_demod_if.sv
// Recovered-sample stream interface for pwm_audio_demod.
// The demodulator drives the master side; the consumer (logger, loopback checker) the slave side.
interface pwm_audio_demod_if #(
  parameter int unsigned SAMPLE_BITS = 7
);
  logic [SAMPLE_BITS-1:0] out_sample;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output out_sample,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_sample,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pwm_audio_demod.sv
// PWM audio demodulator: aligns to the PWM period marker, undoes the per-period polarity
// inversion, counts effective-high cycles per period and hands the count out on a
// single-entry valid/ready register with sticky overrun and period-length error flags.
// Optional build macro PWM_AUDIO_DEMOD_AVG2_EN averages pairs of clean periods before output.
module pwm_audio_demod #(
  parameter int unsigned PERIOD      = 100,
  parameter int unsigned SAMPLE_BITS = $clog2(PERIOD + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      pwm_in,
  input  logic                      period_start,
  input  logic                      sample_phase,
  input  logic                      clear_err,
  pwm_audio_demod_if.master         out_if,
  output logic                      overrun,
  output logic                      period_err
);

  localparam logic [SAMPLE_BITS-1:0] PeriodVal = SAMPLE_BITS'(PERIOD);
  localparam logic [SAMPLE_BITS-1:0] One       = SAMPLE_BITS'(1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [SAMPLE_BITS-1:0] cyc_q, cyc_d;
  logic [SAMPLE_BITS-1:0] acc_q, acc_d;
  logic                   phase_q, phase_d;
  logic [SAMPLE_BITS-1:0] out_sample_q, out_sample_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   period_err_q, period_err_d;

  logic                   clean;
  logic                   err_set;
  logic                   capture;
  logic [SAMPLE_BITS-1:0] cap_val;
  logic                   ovr_set;

  // Effective bit with the phase latched at this start, and with the phase held for the period.
  logic eff_new, eff_run;
  assign eff_new = pwm_in ^ ~sample_phase;
  assign eff_run = pwm_in ^ ~phase_q;

  // Alignment FSM and per-period integrator; disabled cycles leave it untouched.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    clean   = 1'b0;
    err_set = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (period_start) begin
            state_d = StRun;
            phase_d = sample_phase;
            cyc_d   = One;
            acc_d   = SAMPLE_BITS'(eff_new);
          end
        end
        StRun: begin
          if (period_start) begin
            // The closing start cycle belongs to the next period.
            clean   = (cyc_q == PeriodVal);
            err_set = (cyc_q != PeriodVal);
            phase_d = sample_phase;
            cyc_d   = One;
            acc_d   = SAMPLE_BITS'(eff_new);
          end else if (cyc_q == PeriodVal) begin
            err_set = 1'b1;
            state_d = StIdle;
            cyc_d   = '0;
            acc_d   = '0;
          end else begin
            acc_d = acc_q + SAMPLE_BITS'(eff_run);
            cyc_d = cyc_q + One;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef PWM_AUDIO_DEMOD_AVG2_EN
  logic [SAMPLE_BITS-1:0] held_q, held_d;
  logic                   held_valid_q, held_valid_d;
  logic [SAMPLE_BITS:0]   pair_sum;

  // Round-half-up mean of the held and current periods cancels the polarity bias.
  assign pair_sum = {1'b0, held_q} + {1'b0, acc_q} + {{SAMPLE_BITS{1'b0}}, 1'b1};

  // Pairing: first clean period is held, the second releases the averaged sample.
  always_comb begin
    held_d       = held_q;
    held_valid_d = held_valid_q;
    capture      = 1'b0;
    cap_val      = pair_sum[SAMPLE_BITS:1];
    if (err_set) begin
      held_valid_d = 1'b0;
    end else if (clean) begin
      if (held_valid_q) begin
        capture      = 1'b1;
        held_valid_d = 1'b0;
      end else begin
        held_d       = acc_q;
        held_valid_d = 1'b1;
      end
    end
  end

  // Held-half storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q       <= '0;
      held_valid_q <= 1'b0;
    end else begin
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
    end
  end
`else
  // Every clean period goes straight to the output register.
  always_comb begin
    capture = clean;
    cap_val = acc_q;
  end
`endif

  // Output register handshake and sticky flags; set events win over clear_err.
  always_comb begin
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    period_err_d = period_err_q;
    ovr_set      = capture && out_valid_q && !out_if.out_ready;
    if (capture) begin
      out_sample_d = cap_val;
      out_valid_d  = 1'b1;
    end else if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (clear_err) begin
      overrun_d    = 1'b0;
      period_err_d = 1'b0;
    end
    if (ovr_set) overrun_d = 1'b1;
    if (err_set) period_err_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cyc_q        <= '0;
      acc_q        <= '0;
      phase_q      <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      period_err_q <= period_err_d;
    end
  end

  assign out_if.out_sample = out_sample_q;
  assign out_if.out_valid  = out_valid_q;
  assign overrun           = overrun_q;
  assign period_err        = period_err_q;

endmodule

// File: doc/pwm_audio_demod.md
Name: pwm_audio_demod

Overview:
- Receive-side counterpart of the demo's 1-bit PWM audio output.
- Takes the PWM bit stream plus the period marker and the polarity phase bit, and undoes the per-period polarity inversion.
- Integrates high cycles over each PWM period and delivers the recovered sample over a valid/ready interface.
- Sits in the test/capture path, e.g. an FPGA loopback or sample logger, next to the demo top.

Parameters:
PERIOD, 100, active (enabled) clock cycles per PWM period; must be >= 2
SAMPLE_BITS, $clog2(PERIOD+1), width of the recovered sample (derived; do not override)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count-enable; cycles with enable low are ignored entirely
pwm_in  input  1  PWM audio bit from the demo
period_start  input  1  high on the enabled cycle where the PWM counter is 0
sample_phase  input  1  sample counter bit 0; effective bit = pwm_in ^ !phase
clear_err  input  1  clears the sticky error flags
out_sample  output  SAMPLE_BITS  recovered sample, number of effective-high cycles in the period
out_valid  output  1  out_sample valid
out_ready  input  1  consumer accepts when out_valid && out_ready
overrun  output  1  sticky: an unaccepted sample was overwritten
period_err  output  1  sticky: period length was not equal to PERIOD

Behaviour:
- Reset (async, active-high): all state clears.
  - out_sample=0, out_valid=0, overrun=0, period_err=0.
  - Internal state goes to IDLE, cyc=0, acc=0.
- States:
  - IDLE: not aligned. All inputs except period_start are ignored.
  - RUN: aligned to the PWM period.
- A cycle counts only when enable=1. With enable=0, no state changes except the output handshake and clear_err.
- IDLE -> RUN on an enabled period_start.
  - phase_q <= sample_phase.
  - cyc <= 1.
  - acc <= effective bit of that cycle, computed with the new phase.
- RUN, enabled cycle without period_start:
  - acc += pwm_in ^ !phase_q.
  - cyc += 1, saturating at PERIOD.
  - When cyc is already PERIOD (the period overran), set period_err and return to IDLE. acc is discarded and no sample is emitted.
- RUN, enabled cycle with period_start:
  - If cyc == PERIOD, the period closed cleanly: capture acc (the current cycle is excluded) into the output register.
  - Otherwise the period was short: set period_err and emit nothing.
  - In either case, restart the period the same way as IDLE->RUN: new phase_q, cyc=1, acc=effective bit of this cycle.
- sample_phase is sampled only at period_start; changes mid-period have no effect.
- acc range is 0..PERIOD and fits SAMPLE_BITS with no wrap.
- Output register (single entry):
  - A capture sets out_valid=1 and updates out_sample in the cycle after the closing period_start (latency 1 clock).
  - Acceptance (out_valid && out_ready) with no capture in the same cycle: out_valid <= 0. out_sample holds its value.
  - Capture in the same cycle as acceptance: the new sample loads, out_valid stays 1, no overrun.
  - Capture while out_valid=1 and out_ready=0: the new sample overwrites the old one and overrun is set.
- Sticky flags:
  - Set events take priority over clear_err in the same cycle.
  - clear_err otherwise clears both flags.
  - reset clears everything regardless.
- Reset asserted mid-period: the partial period is lost. The first period_start after reset only aligns (no sample).

Optional Feature:
- Macro: PWM_AUDIO_DEMOD_AVG2_EN.
- When defined:
  - Clean periods pair up: the first clean sample is held, and the second produces out_sample = (a + b + 1) >> 1, computed at SAMPLE_BITS+1 width. This cancels the alternating-polarity bias.
  - Only paired results reach the output register, so out_valid pulses at most once per two periods.
  - Any period_err or return to IDLE discards the held half.
- When undefined: every clean period produces an output directly, as above.

Test Plan:
- PERIOD=100, enable=1, phase=1, pwm high on PWM counter values 0..36 -> after the first aligning start, each following period_start gives out_sample=37, out_valid=1 one cycle later.
- Same sample with phase=0 (pwm high 63 cycles per period) -> out_sample=37. Phase toggling every period -> 37 every period.
- enable=0 on alternate cycles (200 clocks per period) -> result unchanged, 37. A 99-enabled-cycle period -> period_err=1, no sample, next clean period emits. A 101st cycle without start -> period_err, IDLE.
- out_ready=0 across two captures (37 then 50) -> overrun=1, out_sample=50. Ready pulse -> out_valid=0. clear_err -> overrun=0.
- reset asserted mid-period at cycle 40 -> all outputs 0 immediately. First following period_start emits nothing, the second emits.
- PWM_AUDIO_DEMOD_AVG2_EN, clean samples 37 then 40 -> single out_sample=39, out_valid once per two periods.
